// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment capture decoder.
// Segment patterns are {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } cap_state_t;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from a segment pattern to BCD digit plus blank/err flags.
// Blank and unknown patterns both report digit 0; the flags tell them apart.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       blank,
  output logic       err
);

  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    err   = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Snoops a multiplexed 4-digit 7-segment display, captures each digit once it
// has been stable for STABLE_CNT samples, and emits a frame when all four lock.
//
// state  | meaning
// SEEK   | waiting for a one-hot digit enable
// SETTLE | counting consecutive identical {seg,an} samples
// LOCKED | digit captured; waiting for the inputs to move on
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [6:0]                  seg_in,
  input  logic [NUM_DIGITS-1:0]       an_in,
  input  logic                        frame_ready,
  input  logic                        clr_overrun,
  output logic                        frame_valid,
  output logic [4*NUM_DIGITS-1:0]     frame_digits,
  output logic [NUM_DIGITS-1:0]       frame_blank,
  output logic [NUM_DIGITS-1:0]       frame_err,
  output logic                        overrun
);

  logic [6:0]              seg_s1, seg_s2;
  logic [NUM_DIGITS-1:0]   an_s1, an_s2;
  logic [10:0]             samp_cur, samp_prev;
  logic                    an_ok, same;

  cap_state_t              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    capture;

  logic [3:0]              dec_digit;
  logic                    dec_blank, dec_err;

  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d, err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_nxt;
  logic                    complete, overrun_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      an_s1  <= '0;
      an_s2  <= '0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      an_s1  <= an_in;
      an_s2  <= an_s1;
    end
  end

  assign samp_cur = {seg_s2, an_s2};
  assign an_ok    = is_onehot(an_s2);
  assign same     = (samp_cur == samp_prev);

  seg7_pattern_decode u_decode (
    .pattern (seg_s2),
    .digit   (dec_digit),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SEEK;
      cnt_q     <= '0;
      samp_prev <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      samp_prev <= samp_cur;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      SEEK: begin
        if (an_ok) begin
          state_d = SETTLE;
          cnt_d   = 4'd1;
        end
      end
      SETTLE: begin
        if (!an_ok) begin
          state_d = SEEK;
          cnt_d   = 4'd0;
        end else if (!same) begin
          cnt_d = 4'd1;
        end else if (cnt_q == 4'(STABLE_CNT - 1)) begin
          capture = 1'b1;
          state_d = LOCKED;
          cnt_d   = 4'(STABLE_CNT);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      LOCKED: begin
        if (!same) begin
          if (an_ok) begin
            state_d = SETTLE;
            cnt_d   = 4'd1;
          end else begin
            state_d = SEEK;
            cnt_d   = 4'd0;
          end
        end
      end
      default: begin
        state_d = SEEK;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Next digit store is computed combinationally so a completing capture
  // lands in the frame on the same edge.
  always_comb begin
    dig_d    = dig_q;
    blank_d  = blank_q;
    err_d    = err_q;
    seen_nxt = seen_q;
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (an_s2[i]) begin
          dig_d[4*i +: 4] = dec_digit;
          blank_d[i]      = dec_blank;
          err_d[i]        = dec_err;
        end
      end
      seen_nxt = seen_q | an_s2;
    end
  end

  assign complete    = capture && (seen_nxt == '1);
  assign overrun_set = complete && frame_valid && !frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q        <= '0;
      blank_q      <= '0;
      err_q        <= '0;
      seen_q       <= '0;
      frame_valid  <= 1'b0;
      frame_digits <= '0;
      frame_blank  <= '0;
      frame_err    <= '0;
      overrun      <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      blank_q <= blank_d;
      err_q   <= err_d;
      if (complete) begin
        seen_q <= '0;
        if (!frame_valid || frame_ready) begin
          frame_valid  <= 1'b1;
          frame_digits <= dig_d;
          frame_blank  <= blank_d;
          frame_err    <= err_d;
        end
      end else begin
        seen_q <= seen_nxt;
        if (frame_valid && frame_ready) frame_valid <= 1'b0;
      end
      if (overrun_set)      overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder: table of full display scans plus
// hand sequences for latency, overrun, same-cycle accept, SEEK and reset.
module tb_seg7_capture_decoder;

  localparam logic [6:0] P0 = 7'b0111111;
  localparam logic [6:0] P1 = 7'b0000110;
  localparam logic [6:0] P2 = 7'b1011011;
  localparam logic [6:0] P3 = 7'b1001111;
  localparam logic [6:0] P4 = 7'b1100110;
  localparam logic [6:0] P5 = 7'b1101101;
  localparam logic [6:0] P6 = 7'b1111101;
  localparam logic [6:0] P7 = 7'b0000111;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1101111;
  localparam logic [6:0] PB = 7'b0000000;
  localparam logic [6:0] PX = 7'b1010101;
  localparam logic [6:0] PY = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  an_in = '0;
  logic        frame_ready = 1'b0;
  logic        clr_overrun = 1'b0;
  logic        frame_valid;
  logic [15:0] frame_digits;
  logic [3:0]  frame_blank;
  logic [3:0]  frame_err;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int frame_cnt = 0;
  int base;
  logic [15:0] mon_dig;
  logic [3:0]  mon_blank, mon_err;

  typedef struct {
    logic [3:0][6:0] pats;
    logic [15:0]     dig;
    logic [3:0]      blk;
    logic [3:0]      err;
  } vec_t;

  vec_t vecs [5];

  seg7_capture_decoder #(.STABLE_CNT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .an_in        (an_in),
    .frame_ready  (frame_ready),
    .clr_overrun  (clr_overrun),
    .frame_valid  (frame_valid),
    .frame_digits (frame_digits),
    .frame_blank  (frame_blank),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && frame_valid && frame_ready) begin
      frame_cnt = frame_cnt + 1;
      mon_dig   = frame_digits;
      mon_blank = frame_blank;
      mon_err   = frame_err;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seg_in = '0;
    an_in = '0;
    frame_ready = 1'b0;
    clr_overrun = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic scan(input logic [3:0][6:0] pats, input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        an_in  = 4'(1 << i);
        seg_in = pats[i];
        repeat (8) @(negedge clk);
      end
    end
    an_in = '0;
    repeat (4) @(negedge clk);
  endtask

  // Drives digit 3 and stops after 5 rising edges, one short of completion.
  task automatic drive_last(input logic [6:0] p);
    an_in  = 4'b1000;
    seg_in = p;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{pats: {P4, P3, P2, P1}, dig: 16'h4321, blk: 4'b0000, err: 4'b0000};
    vecs[1] = '{pats: {PX, PB, P5, P7}, dig: 16'h0057, blk: 4'b0100, err: 4'b1000};
    vecs[2] = '{pats: {P6, P8, P9, P0}, dig: 16'h6890, blk: 4'b0000, err: 4'b0000};
    vecs[3] = '{pats: {PB, PB, PB, PB}, dig: 16'h0000, blk: 4'b1111, err: 4'b0000};
    vecs[4] = '{pats: {PY, PY, PY, PY}, dig: 16'h0000, blk: 4'b0000, err: 4'b1111};

    repeat (2) @(negedge clk);
    check("rst_valid", frame_valid, 0);
    check("rst_digits", frame_digits, 0);
    check("rst_blank", frame_blank, 0);
    check("rst_err", frame_err, 0);
    check("rst_overrun", overrun, 0);

    // table of full scans, ready held high
    do_reset();
    frame_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      base = frame_cnt;
      scan(vecs[v].pats, 4'hF);
      check($sformatf("vec%0d_count", v), frame_cnt, base + 1);
      check($sformatf("vec%0d_digits", v), mon_dig, vecs[v].dig);
      check($sformatf("vec%0d_blank", v), mon_blank, vecs[v].blk);
      check($sformatf("vec%0d_err", v), mon_err, vecs[v].err);
    end

    // latency: valid rises on the 6th edge after the last digit changes
    do_reset();
    frame_ready = 1'b1;
    scan(vecs[0].pats, 4'b0111);
    drive_last(P4);
    check("lat_not_yet", frame_valid, 0);
    @(negedge clk);
    check("lat_valid", frame_valid, 1);
    check("lat_digits", frame_digits, 16'h4321);
    @(negedge clk);
    check("lat_accepted", frame_valid, 0);
    an_in = '0;
    repeat (4) @(negedge clk);

    // overrun: second frame dropped while first is held
    do_reset();
    scan(vecs[0].pats, 4'hF);
    check("hold1_valid", frame_valid, 1);
    check("hold1_digits", frame_digits, 16'h4321);
    scan(vecs[2].pats, 4'hF);
    check("ovr_valid", frame_valid, 1);
    check("ovr_digits_kept", frame_digits, 16'h4321);
    check("ovr_set", overrun, 1);
    // completion coinciding with accept loads the new frame
    scan(vecs[2].pats, 4'b0111);
    drive_last(P6);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    check("same_valid", frame_valid, 1);
    check("same_digits", frame_digits, 16'h6890);
    check("same_overrun_kept", overrun, 1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("clr_overrun", overrun, 0);
    check("clr_valid_kept", frame_valid, 1);
    an_in = '0;
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("drained", frame_valid, 0);

    // unstable digit 0 never captures
    do_reset();
    frame_ready = 1'b1;
    base = frame_cnt;
    an_in = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      seg_in = k[0] ? P2 : P1;
      repeat (2) @(negedge clk);
    end
    an_in = '0;
    repeat (4) @(negedge clk);
    scan(vecs[0].pats, 4'b1110);
    check("toggle_no_frame", frame_cnt, base);
    scan({P4, P3, P2, P9}, 4'b0001);
    check("toggle_then_frame", frame_cnt, base + 1);
    check("toggle_digits", mon_dig, 16'h4329);

    // non-one-hot enables stay in SEEK
    do_reset();
    frame_ready = 1'b1;
    base = frame_cnt;
    an_in = 4'b0011;
    seg_in = P1;
    repeat (10) @(negedge clk);
    an_in = 4'b0000;
    repeat (10) @(negedge clk);
    scan(vecs[0].pats, 4'b1110);
    check("seek_no_frame", frame_cnt, base);
    check("seek_valid", frame_valid, 0);

    // reset mid-settle with a pending frame and overrun
    do_reset();
    scan(vecs[0].pats, 4'hF);
    scan(vecs[2].pats, 4'hF);
    check("pre_rst_overrun", overrun, 1);
    scan(vecs[1].pats, 4'b0011);
    an_in = 4'b0100;
    seg_in = P3;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_valid", frame_valid, 0);
    check("arst_digits", frame_digits, 0);
    check("arst_blank", frame_blank, 0);
    check("arst_err", frame_err, 0);
    check("arst_overrun", overrun, 0);
    an_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);
    base = frame_cnt;
    scan(vecs[0].pats, 4'b1100);
    check("post_rst_no_frame", frame_cnt, base);
    scan(vecs[0].pats, 4'b0011);
    check("post_rst_frame", frame_cnt, base + 1);
    check("post_rst_digits", mon_dig, 16'h4321);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_capture_decoder.md
SEG7_CAPTURE_DECODER -- requirements
Module: seg7_capture_decoder

Interface
REQ-001 Parameter: STABLE_CNT, default 4, number of consecutive identical synchronized samples (range 2..15) before a digit is captured.
REQ-002 Port: clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: seg_in  input  7  segment lines {g,f,e,d,c,b,a}, bit0=a, active-high, asynchronous to clk.
REQ-005 Port: an_in  input  4  digit enables, active-high, expected one-hot, asynchronous to clk; bit i selects digit i.
REQ-006 Port: frame_ready  input  1  downstream accepts the frame when high with frame_valid.
REQ-007 Port: clr_overrun  input  1  synchronous clear of overrun.
REQ-008 Port: frame_valid  output  1  frame_digits, frame_blank and frame_err are valid.
REQ-009 Port: frame_digits  output  16  digit i at bits [4i+3:4i], BCD 0..9.
REQ-010 Port: frame_blank  output  4  bit i set when digit i showed an all-off pattern.
REQ-011 Port: frame_err  output  4  bit i set when digit i showed a non-table, non-blank pattern.
REQ-012 Port: overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-013 seg_in and an_in SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 Decode table (seg, bit6..0): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, blank=0000000.
REQ-015 A blank pattern SHALL yield digit 0 with the blank bit set; any other unlisted pattern SHALL yield digit 0 with the err bit set.
REQ-016 Capture FSM states: SEEK, SETTLE, LOCKED; reset state SEEK.
REQ-017 SEEK: a one-hot synchronized an_in moves to SETTLE with stability count = 1; a non-one-hot an_in stays in SEEK.
REQ-018 SETTLE: each sample identical to the previous {seg,an} increments the count; any difference restarts the count at 1 with the new value; a non-one-hot an_in returns to SEEK.
REQ-019 SETTLE: on the edge where the count reaches STABLE_CNT, the module SHALL write the decoded digit, blank and err for the selected digit, set its seen bit, and move to LOCKED.
REQ-020 LOCKED: the module SHALL hold until synchronized {seg,an} changes, then re-enter SETTLE (count 1), or SEEK if an_in is not one-hot.
REQ-021 When the seen mask becomes 4'hF, the same edge SHALL load frame_* from the digit registers, assert frame_valid, and clear the seen mask to 0.
REQ-022 Handshake: frame_valid && frame_ready SHALL drop frame_valid on the next edge unless a new frame loads on that edge.
REQ-023 Frame outputs SHALL stay stable while frame_valid is high and frame_ready is low.
REQ-024 A completion while frame_valid=1 and frame_ready=0 SHALL drop the new frame, keep the old frame, and set overrun.
REQ-025 A completion in the same cycle as an accept SHALL load the new frame, keep frame_valid high, and leave overrun unchanged.
REQ-026 overrun SHALL clear on clr_overrun=1; a set event in the same cycle wins over the clear.
REQ-027 Latency: frame_valid SHALL rise exactly 2+STABLE_CNT cycles after the last missing digit's inputs settle.

Reset
REQ-028 On rst_n low, asynchronously: FSM=SEEK, count=0, seen mask=0, digit registers=0, frame_valid=0, frame_digits=0, frame_blank=0, frame_err=0, overrun=0, and synchronizer flops=0.
REQ-029 Reset asserted mid-settle or while frame_valid is high SHALL discard all partial and pending data; no frame is emitted after release until four new digits lock.

Structure
REQ-030 The segment-pattern constants (REQ-014), the FSM state enum, and the digit-count constant 4 SHALL reside in shared package seg7_pkg.
REQ-031 The pattern-to-{digit,blank,err} mapping SHALL be one combinational sub-module, seg7_pattern_decode.

Verification (STABLE_CNT=4)
REQ-032 Cycle an_in 0001/0010/0100/1000 with patterns for 1,2,3,4, each held 8 cycles, frame_ready=1 -> one frame: digits 16'h4321, blank=0, err=0.
REQ-033 Digit 2 driven as 0000000 and digit 3 as 1010101 -> frame_blank=0100, frame_err=1000, and both digit fields are 0.
REQ-034 seg_in toggles every 2 cycles on digit 0 -> no capture; seen[0] stays 0 and no frame is emitted.
REQ-035 Hold frame_ready=0 across two completed scans -> the first frame is held unchanged and overrun=1; clr_overrun pulse -> overrun=0.
REQ-036 an_in=0011 or 0000 for 10 cycles -> FSM stays in SEEK and nothing is captured; rst_n pulsed low mid-SETTLE -> all outputs are 0 immediately.
